car_park_ctrl_p: RTL



---
 rtl/car_park_ctrl_p.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/car_park_ctrl_p.sv
// Car park gate controller: keypad password FSM with occupancy tracking,
// retry lockout, entry timeout and a blinking error indication.
`timescale 1ns/1ps
module car_park_ctrl_p #(
   parameter int CAPACITY    = 8,
   parameter int PW_WIDTH    = 2,
   parameter int PASSWORD_1  = 1,
   parameter int PASSWORD_2  = 2,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 64,
   parameter int LOCKOUT_CYC = 128,
   parameter int BLINK_CYC   = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sensor_entrance,
   input  logic                            sensor_exit,
   input  logic                            car_departed,
   input  logic [PW_WIDTH-1:0]             password_1,
   input  logic [PW_WIDTH-1:0]             password_2,
   input  logic                            password_valid,
   output logic                            GREEN_LED,
   output logic                            RED_LED,
   output logic [6:0]                      HEX_1,
   output logic [6:0]                      HEX_2,
   output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
   output logic                            full
);

   localparam int OCC_W   = $clog2(CAPACITY+1);
   localparam int TMAX    = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
   localparam int TIMER_W = $clog2(TMAX+1);
   localparam int TRY_W   = $clog2(MAX_TRIES+1);
   localparam int BLINK_W = $clog2(BLINK_CYC+1);

   localparam logic [6:0] G_BLANK = 7'h7F;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_N     = 7'b0101011;
   localparam logic [6:0] G_6     = 7'b0000010;
   localparam logic [6:0] G_0     = 7'b1000000;
   localparam logic [6:0] G_5     = 7'b0010010;
   localparam logic [6:0] G_P     = 7'b0001100;
   localparam logic [6:0] G_F     = 7'b0001110;
   localparam logic [6:0] G_L     = 7'b1000111;

   typedef enum logic [2:0] {
      S_IDLE, S_FULL, S_WAIT, S_WRONG, S_RIGHT, S_STOP, S_LOCK
   } state_t;

   state_t               state, state_nx;
   logic [TRY_W-1:0]     tries, tries_nx;
   logic [TIMER_W-1:0]   timer, timer_nx;
   logic [BLINK_W-1:0]   blink_cnt, blink_nx;
   logic                 blink_red, blink_red_nx;
   logic [OCC_W-1:0]     occ_nx;
   logic                 inc;
   logic                 pw_match;
   logic [15:0]          out_nx;

   // Moore output decode: {green, red, hex_1, hex_2}
   function automatic logic [15:0] decode_out(input state_t s, input logic blink);
      case (s)
         S_FULL:  decode_out = {1'b0, 1'b1,  G_F, G_L};
         S_WAIT:  decode_out = {1'b0, 1'b1,  G_E, G_N};
         S_WRONG: decode_out = {1'b0, blink, G_E, G_E};
         S_RIGHT: decode_out = {1'b1, 1'b0,  G_6, G_0};
         S_STOP:  decode_out = {1'b0, 1'b1,  G_5, G_P};
         S_LOCK:  decode_out = {1'b0, 1'b1,  G_L, G_L};
         default: decode_out = {1'b0, 1'b0,  G_BLANK, G_BLANK};
      endcase
   endfunction

   assign pw_match = (password_1 == PW_WIDTH'(PASSWORD_1)) &&
                     (password_2 == PW_WIDTH'(PASSWORD_2));

   always_comb begin
      state_nx     = state;
      tries_nx     = tries;
      timer_nx     = timer;
      blink_nx     = blink_cnt;
      blink_red_nx = blink_red;
      inc          = 1'b0;
      case (state)
         S_IDLE: begin
            if (sensor_entrance) begin
               if (full) begin
                  state_nx = S_FULL;
               end else begin
                  state_nx = S_WAIT;
                  timer_nx = '0;
                  tries_nx = '0;
               end
            end
         end
         S_FULL: begin
            if (!sensor_entrance) begin
               state_nx = S_IDLE;
            end else if (car_departed || !full) begin
               state_nx = S_WAIT;
               timer_nx = '0;
               tries_nx = '0;
            end
         end
         S_WAIT, S_WRONG: begin
            if (password_valid) begin
               timer_nx = '0;
               if (pw_match) begin
                  state_nx = S_RIGHT;
               end else begin
                  tries_nx = tries + TRY_W'(1);
                  if (tries == TRY_W'(MAX_TRIES-1)) begin
                     state_nx = S_LOCK;
                  end else begin
                     state_nx     = S_WRONG;
                     blink_nx     = '0;
                     blink_red_nx = 1'b1;
                  end
               end
            end else if (timer == TIMER_W'(TIMEOUT_CYC-1)) begin
               state_nx = S_IDLE;
            end else begin
               timer_nx = timer + TIMER_W'(1);
               if (state == S_WRONG) begin
                  if (blink_cnt == BLINK_W'(BLINK_CYC-1)) begin
                     blink_nx     = '0;
                     blink_red_nx = ~blink_red;
                  end else begin
                     blink_nx = blink_cnt + BLINK_W'(1);
                  end
               end
            end
         end
         S_RIGHT: begin
            if (sensor_exit) begin
               inc      = 1'b1;
               state_nx = sensor_entrance ? S_STOP : S_IDLE;
            end
         end
         S_STOP: begin
            if (password_valid && pw_match)
               state_nx = full ? S_FULL : S_RIGHT;
         end
         S_LOCK: begin
            if (timer == TIMER_W'(LOCKOUT_CYC-1))
               state_nx = S_IDLE;
            else
               timer_nx = timer + TIMER_W'(1);
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Simultaneous arrival and departure cancel out; both ends saturate.
   always_comb begin
      occ_nx = occupancy;
      if (inc && !car_departed) begin
         if (occupancy != OCC_W'(CAPACITY))
            occ_nx = occupancy + OCC_W'(1);
      end else if (!inc && car_departed) begin
         if (occupancy != '0)
            occ_nx = occupancy - OCC_W'(1);
      end
   end

   assign out_nx = decode_out(state_nx, blink_red_nx);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         tries     <= '0;
         timer     <= '0;
         blink_cnt <= '0;
         blink_red <= 1'b0;
         occupancy <= '0;
         full      <= 1'b0;
         GREEN_LED <= 1'b0;
         RED_LED   <= 1'b0;
         HEX_1     <= G_BLANK;
         HEX_2     <= G_BLANK;
      end else begin
         state     <= state_nx;
         tries     <= tries_nx;
         timer     <= timer_nx;
         blink_cnt <= blink_nx;
         blink_red <= blink_red_nx;
         occupancy <= occ_nx;
         full      <= (occ_nx == OCC_W'(CAPACITY));
         GREEN_LED <= out_nx[15];
         RED_LED   <= out_nx[14];
         HEX_1     <= out_nx[13:7];
         HEX_2     <= out_nx[6:0];
      end
   end

endmodule
